// File: rtl/key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_debouncer                                              |
// | Description : Debounces raw active-low push-button pins for the key and  |
// |               display unit. Each key is synchronized through two flops   |
// |               and must hold a new level for DEBOUNCE_CYCLES clocks        |
// |               before the clean level changes. Accepted changes also      |
// |               produce registered one-cycle press/release pulses.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Optional feature macro: KEY_AUTOREPEAT_EN                                |
// |   defined   : a held key emits extra press pulses, the first one         |
// |               REPEAT_DELAY cycles after the press pulse and then one     |
// |               every REPEAT_PERIOD cycles until the release is accepted.  |
// |   undefined : press pulses only on accepted presses; REPEAT_* unused.   |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   NUM_KEYS         number of keys                                        |
// |   DEBOUNCE_CYCLES  stable cycles required before a level is accepted (>=2)|
// |   REPEAT_DELAY     press pulse to first auto-repeat, in cycles           |
// |   REPEAT_PERIOD    cycles between later auto-repeats (<= REPEAT_DELAY)   |
// | Ports                                                                    |
// |   clk_i            IO clock                                              |
// |   rst_i            synchronous active-high reset                         |
// |   keys_raw_i       raw pin levels, asynchronous, 0 = pressed             |
// |   keys_clean_o     debounced levels, 0 = pressed                         |
// |   press_pulse_o    one-cycle pulse per accepted press (and auto-repeat)  |
// |   release_pulse_o  one-cycle pulse per accepted release                  |
// +--------------------------------------------------------------------------+

module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 150000,
  parameter int REPEAT_DELAY    = 7500000,
  parameter int REPEAT_PERIOD   = 1500000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] keys_raw_i,
  output logic [NUM_KEYS-1:0] keys_clean_o,
  output logic [NUM_KEYS-1:0] press_pulse_o,
  output logic [NUM_KEYS-1:0] release_pulse_o
);

  // ---------------------------------------------------------------------
  // Parameter sanity: the stability counter needs at least one bit, and
  // the repeat counter is sized from REPEAT_DELAY so the period must fit.
  // ---------------------------------------------------------------------
  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 ||
        REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
      $error("key_debouncer: illegal DEBOUNCE/REPEAT parameter combination");
    end
  endgenerate

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer; only sync2_q feeds the key logic.
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  // Accepted level per key: 1 = STABLE_HI (released), 0 = STABLE_LO.
  logic [NUM_KEYS-1:0] clean_q,   clean_d;
  logic [NUM_KEYS-1:0] press_q,   press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;

  // Per-key stability counters.
  logic [CNT_W-1:0] cnt_q [NUM_KEYS];
  logic [CNT_W-1:0] cnt_d [NUM_KEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam int               RCNT_W      = $clog2(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RCNT_DELAY  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_PERIOD = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic {
    PH_INITIAL = 1'b0,
    PH_REPEAT  = 1'b1
  } phase_e;

  logic [RCNT_W-1:0] rcnt_q  [NUM_KEYS];
  logic [RCNT_W-1:0] rcnt_d  [NUM_KEYS];
  phase_e            phase_q [NUM_KEYS];
  phase_e            phase_d [NUM_KEYS];
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    clean_d   = clean_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
`ifdef KEY_AUTOREPEAT_EN
    rcnt_d    = rcnt_q;
    phase_d   = phase_q;
`endif

    for (int k = 0; k < NUM_KEYS; k++) begin
      if (sync2_q[k] == clean_q[k]) begin
        // Level matches the accepted one: any glitch restarts the window.
        cnt_d[k] = '0;
      end else if (cnt_q[k] != CNT_LAST) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end else begin
        // Window complete: accept the new level and flag the edge.
        cnt_d[k]     = '0;
        clean_d[k]   = sync2_q[k];
        press_d[k]   = ~sync2_q[k];
        release_d[k] = sync2_q[k];
      end

`ifdef KEY_AUTOREPEAT_EN
      // press_d/release_d only hold acceptance information at this point,
      // so an acceptance edge restarts the repeat timing. The repeat
      // counter only runs while the accepted level is pressed, and the
      // acceptance branch also masks any repeat in a release cycle.
      if (press_d[k] || release_d[k] || clean_q[k]) begin
        rcnt_d[k]  = '0;
        phase_d[k] = PH_INITIAL;
      end else if (phase_q[k] == PH_INITIAL && rcnt_q[k] == RCNT_DELAY) begin
        press_d[k] = 1'b1;
        rcnt_d[k]  = '0;
        phase_d[k] = PH_REPEAT;
      end else if (phase_q[k] == PH_REPEAT && rcnt_q[k] == RCNT_PERIOD) begin
        press_d[k] = 1'b1;
        rcnt_d[k]  = '0;
      end else begin
        rcnt_d[k]  = rcnt_q[k] + 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      clean_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q[k]  <= '0;
        phase_q[k] <= PH_INITIAL;
`endif
      end
    end else begin
      sync1_q   <= keys_raw_i;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_q    <= rcnt_d;
      phase_q   <= phase_d;
`endif
    end
  end

  assign keys_clean_o    = clean_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_key_debouncer                                           |
// | Description : Directed self-checking bench for key_debouncer with        |
// |               DEBOUNCE_CYCLES=8, REPEAT_DELAY=16, REPEAT_PERIOD=4.        |
// |               A raw change driven just after edge N is first sampled at  |
// |               edge N+1 and accepted at edge N+10.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_key_debouncer;

  localparam int NK = 4;
  localparam int DC = 8;
  localparam int RD = 16;
  localparam int RP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] raw = '1;
  logic [NK-1:0] clean;
  logic [NK-1:0] press;
  logic [NK-1:0] rel;

  int total = 0;
  int bad   = 0;

  key_debouncer #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .keys_raw_i      (raw),
    .keys_clean_o    (clean),
    .press_pulse_o   (press),
    .release_pulse_o (rel)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NK-1:0] ec, ep, er;
    raw = 4'h0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({clean, press, rel} !== {4'hF, 4'h0, 4'h0}) begin
        bad++;
        $display("FAIL reset_state cyc%0d: got clean=%h press=%h rel=%h want clean=f press=0 rel=0",
                 i, clean, press, rel);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'h0 : 4'hF;
      ep = (i == 10) ? 4'hF : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, ep, 4'h0}) begin
        bad++;
        $display("FAIL reset_release_press i=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=0",
                 i, clean, press, rel, ec, ep);
      end
    end
    raw = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hF : 4'h0;
      er = (i == 10) ? 4'hF : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, 4'h0, er}) begin
        bad++;
        $display("FAIL reset_all_release i=%0d: got clean=%h press=%h rel=%h want clean=%h press=0 rel=%h",
                 i, clean, press, rel, ec, er);
      end
    end
  endtask

  task automatic test_single_press();
    logic [NK-1:0] ec, ep, er;
    raw = 4'hE;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hE : 4'hF;
      ep = (i == 10) ? 4'h1 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, ep, 4'h0}) begin
        bad++;
        $display("FAIL single_press i=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=0",
                 i, clean, press, rel, ec, ep);
      end
    end
    raw = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hF : 4'hE;
      er = (i == 10) ? 4'h1 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, 4'h0, er}) begin
        bad++;
        $display("FAIL single_release i=%0d: got clean=%h press=%h rel=%h want clean=%h press=0 rel=%h",
                 i, clean, press, rel, ec, er);
      end
    end
  endtask

  task automatic test_glitch();
    logic [NK-1:0] ec, ep, er;
    // Short burst of 5 low cycles then 2 high cycles: never accepted.
    for (int i = 0; i < 7; i++) begin
      raw = (i < 5) ? 4'hD : 4'hF;
      step();
      total++;
      if ({clean, press, rel} !== {4'hF, 4'h0, 4'h0}) begin
        bad++;
        $display("FAIL glitch_burst i=%0d: got clean=%h press=%h rel=%h want clean=f press=0 rel=0",
                 i, clean, press, rel);
      end
    end
    raw = 4'hD;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hD : 4'hF;
      ep = (i == 10) ? 4'h2 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, ep, 4'h0}) begin
        bad++;
        $display("FAIL glitch_final_press i=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=0",
                 i, clean, press, rel, ec, ep);
      end
    end
    raw = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hF : 4'hD;
      er = (i == 10) ? 4'h2 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, 4'h0, er}) begin
        bad++;
        $display("FAIL glitch_release i=%0d: got clean=%h press=%h rel=%h want clean=%h press=0 rel=%h",
                 i, clean, press, rel, ec, er);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] ec, ep, er;
    raw = 4'h3;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'h3 : 4'hF;
      ep = (i == 10) ? 4'hC : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, ep, 4'h0}) begin
        bad++;
        $display("FAIL simul_press i=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=0",
                 i, clean, press, rel, ec, ep);
      end
    end
    raw = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hF : 4'h3;
      er = (i == 10) ? 4'hC : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, 4'h0, er}) begin
        bad++;
        $display("FAIL simul_release i=%0d: got clean=%h press=%h rel=%h want clean=%h press=0 rel=%h",
                 i, clean, press, rel, ec, er);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [NK-1:0] ec, ep, er;
    raw = 4'hE;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({clean, press, rel} !== {4'hF, 4'h0, 4'h0}) begin
        bad++;
        $display("FAIL midreset_before i=%0d: got clean=%h press=%h rel=%h want clean=f press=0 rel=0",
                 i, clean, press, rel);
      end
    end
    rst = 1'b1;
    step();
    total++;
    if ({clean, press, rel} !== {4'hF, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL midreset_during: got clean=%h press=%h rel=%h want clean=f press=0 rel=0",
               clean, press, rel);
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hE : 4'hF;
      ep = (i == 10) ? 4'h1 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, ep, 4'h0}) begin
        bad++;
        $display("FAIL midreset_after i=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=0",
                 i, clean, press, rel, ec, ep);
      end
    end
    raw = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = (i >= 10) ? 4'hF : 4'hE;
      er = (i == 10) ? 4'h1 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, 4'h0, er}) begin
        bad++;
        $display("FAIL midreset_release i=%0d: got clean=%h press=%h rel=%h want clean=%h press=0 rel=%h",
                 i, clean, press, rel, ec, er);
      end
    end
  endtask

  // Key 2 accepted at edge A (i=10), held until edge A+40, then released;
  // the release is accepted at A+50.
  task automatic test_autorepeat();
    logic [NK-1:0] ec, ep, er;
    raw = 4'hB;
    for (int i = 1; i <= 10; i++) begin
      step();
      ec = (i >= 10) ? 4'hB : 4'hF;
      ep = (i == 10) ? 4'h4 : 4'h0;
      total++;
      if ({clean, press, rel} !== {ec, ep, 4'h0}) begin
        bad++;
        $display("FAIL repeat_accept i=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=0",
                 i, clean, press, rel, ec, ep);
      end
    end
    for (int j = 1; j <= 60; j++) begin
      if (j == 41) raw = 4'hF;
      step();
      ec = (j >= 50) ? 4'hF : 4'hB;
      er = (j == 50) ? 4'h4 : 4'h0;
`ifdef KEY_AUTOREPEAT_EN
      ep = (j >= RD && j <= 48 && ((j - RD) % RP) == 0) ? 4'h4 : 4'h0;
`else
      ep = 4'h0;
`endif
      total++;
      if ({clean, press, rel} !== {ec, ep, er}) begin
        bad++;
        $display("FAIL repeat_hold j=%0d: got clean=%h press=%h rel=%h want clean=%h press=%h rel=%h",
                 j, clean, press, rel, ec, ep, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_autorepeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
